timer_bus_master: RTL and testbench

Bus initiator that programs and monitors one `timer32` instance over its register port (`addr`/`din`/`dout`/`wren`/`rden`). It replaces hard-wired parameters and constant read strobes on that port. On a start command it writes the period, enables the timer, and polls the status flag. Each flag toggle becomes a one-cycle tick and increments an event counter. It sits between control logic (switch/debounce or CPU glue) and a `timer32`, one master per timer.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/timer_bus_master.sv | 174 +++++++++++++++++
 tb/tb_timer_bus_master.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for timer32 and its bus master: register map, CTRL bit
// positions and the master's state encoding.
package timer_pkg;

  localparam logic [1:0] ADDR_PERIOD = 2'b01;
  localparam logic [1:0] ADDR_CTRL   = 2'b10;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_FLAG = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_PER,
    ST_RB_REQ,
    ST_RB_WAIT,
    ST_WR_EN,
    ST_POLL_REQ,
    ST_POLL_WAIT,
    ST_WR_DIS
  } state_t;

endpackage

// File: rtl/timer_bus_master.sv
// Programs one timer32 over its register port, polls the FLAG bit and turns each
// toggle into a tick. Optional PERIOD readback check: TIMER_MASTER_READBACK_EN.
module timer_bus_master
  import timer_pkg::*;
#(
  parameter int          CNT_W      = 16,
  parameter logic [31:0] MIN_PERIOD = 32'd2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      period_in,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             err,
  output logic [1:0]       addr,
  output logic [31:0]      din,
  output logic             wren,
  output logic             rden,
  input  logic [31:0]      dout
);

  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        period_q, period_d;
  logic               stop_pend_q, stop_pend_d;
  logic               shadow_q, shadow_d;
  logic               first_q, first_d;
  logic               tick_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stop_now;
  logic [1:0]         addr_d;
  logic [31:0]        din_d;
  logic               wren_d, rden_d, busy_d;

`ifdef TIMER_MASTER_READBACK_EN
  logic err_q, err_d;
`else
  logic unused_dout;
  assign unused_dout = ^{dout[31:3], dout[1:0]};
`endif

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    stop_pend_d = stop_pend_q;
    shadow_d    = shadow_q;
    first_d     = first_q;
    tick_d      = 1'b0;
    cnt_d       = cnt_q;
`ifdef TIMER_MASTER_READBACK_EN
    err_d       = err_q;
`endif
    // A stop arriving in the last cycle of a bus access still takes effect at its end.
    stop_now    = stop_pend_q | stop;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          period_d    = clamp_period(period_in);
          cnt_d       = '0;
          stop_pend_d = 1'b0;
`ifdef TIMER_MASTER_READBACK_EN
          err_d       = 1'b0;
`endif
          state_d     = ST_WR_PER;
        end
      end
`ifdef TIMER_MASTER_READBACK_EN
      ST_WR_PER:  state_d = stop_now ? ST_WR_DIS : ST_RB_REQ;
      ST_RB_REQ:  state_d = ST_RB_WAIT;
      ST_RB_WAIT: begin
        if (dout != period_q) begin
          err_d   = 1'b1;
          state_d = ST_WR_DIS;
        end else begin
          state_d = stop_now ? ST_WR_DIS : ST_WR_EN;
        end
      end
`else
      ST_WR_PER:  state_d = stop_now ? ST_WR_DIS : ST_WR_EN;
`endif
      ST_WR_EN: begin
        first_d = 1'b1;
        state_d = stop_now ? ST_WR_DIS : ST_POLL_REQ;
      end
      ST_POLL_REQ: state_d = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (first_q) begin
          shadow_d = dout[CTRL_FLAG];
          first_d  = 1'b0;
        end else if (dout[CTRL_FLAG] != shadow_q) begin
          shadow_d = dout[CTRL_FLAG];
          tick_d   = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
        state_d = stop_now ? ST_WR_DIS : ST_POLL_REQ;
      end
      ST_WR_DIS: begin
        stop_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (stop && state_q != ST_IDLE && state_q != ST_WR_DIS && state_d != ST_WR_DIS)
      stop_pend_d = 1'b1;

    // Bus outputs are decoded from the next state so they register in step with it.
    wren_d = (state_d == ST_WR_PER) || (state_d == ST_WR_EN) || (state_d == ST_WR_DIS);
    rden_d = (state_d == ST_RB_REQ) || (state_d == ST_POLL_REQ);
    busy_d = (state_d != ST_IDLE);
    addr_d = 2'b00;
    din_d  = 32'h0;
    case (state_d)
      ST_WR_PER:   begin addr_d = ADDR_PERIOD; din_d = period_d; end
      ST_RB_REQ:   addr_d = ADDR_PERIOD;
      ST_WR_EN:    begin addr_d = ADDR_CTRL; din_d = 32'h1 << CTRL_EN; end
      ST_POLL_REQ: addr_d = ADDR_CTRL;
      ST_WR_DIS:   addr_d = ADDR_CTRL;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      shadow_q    <= 1'b0;
      first_q     <= 1'b0;
      tick        <= 1'b0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      addr        <= 2'b00;
      din         <= 32'h0;
      wren        <= 1'b0;
      rden        <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      shadow_q    <= shadow_d;
      first_q     <= first_d;
      tick        <= tick_d;
      cnt_q       <= cnt_d;
      busy        <= busy_d;
      addr        <= addr_d;
      din         <= din_d;
      wren        <= wren_d;
      rden        <= rden_d;
    end
  end

  always_ff @(posedge clk) begin
    period_q <= period_d;
  end

`ifdef TIMER_MASTER_READBACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign tick_count = cnt_q;

endmodule

// File: tb/tb_timer_bus_master.sv
// Bench for timer_bus_master against a behavioural timer32 model; a second
// instance with CNT_W=4 shares the bus to exercise counter wrap.
module tb_timer_bus_master;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [31:0] period_in = 32'h0;
  logic        busy, tick, err, wren, rden;
  logic [15:0] tick_count;
  logic [1:0]  addr;
  logic [31:0] din;
  logic        busy4, tick4, err4, wren4, rden4;
  logic [3:0]  tc4;
  logic [1:0]  addr4;
  logic [31:0] din4;

  // timer model state
  logic [31:0] tm_period, tm_cnt, tm_dout;
  logic        tm_en, tm_flag;
  int          tm_toggles;
  int          tm_limit = 0;
  logic        tm_clr = 1'b1;
  logic        rb_corrupt = 1'b0;

  int total = 0, bad = 0, proto_bad = 0, tick_seen = 0;
  logic [1:0]  wr_addr_q[$];
  logic [31:0] wr_din_q[$];

`ifdef TIMER_MASTER_READBACK_EN
  localparam int EN_LAT = 3;
`else
  localparam int EN_LAT = 1;
`endif

  always #5 clk = ~clk;

  timer_bus_master #(.CNT_W(16), .MIN_PERIOD(32'd2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .period_in(period_in),
    .busy(busy), .tick(tick), .tick_count(tick_count), .err(err),
    .addr(addr), .din(din), .wren(wren), .rden(rden), .dout(tm_dout));

  timer_bus_master #(.CNT_W(4), .MIN_PERIOD(32'd2)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .period_in(period_in),
    .busy(busy4), .tick(tick4), .tick_count(tc4), .err(err4),
    .addr(addr4), .din(din4), .wren(wren4), .rden(rden4), .dout(tm_dout));

  // Behavioural timer32: FLAG toggles every (PERIOD+1) enabled cycles, capped at tm_limit toggles.
  always @(posedge clk) begin
    if (tm_clr) begin
      tm_en <= 1'b0; tm_flag <= 1'b0; tm_cnt <= 32'h0; tm_toggles <= 0; tm_period <= 32'h0;
    end else begin
      if (wren && addr == 2'b01) tm_period <= din;
      if (wren && addr == 2'b10) begin
        tm_en <= din[0]; tm_cnt <= 32'h0;
      end else if (tm_en) begin
        if (tm_cnt >= tm_period && tm_toggles < tm_limit) begin
          tm_flag <= ~tm_flag; tm_cnt <= 32'h0; tm_toggles <= tm_toggles + 1;
        end else if (tm_cnt < tm_period) tm_cnt <= tm_cnt + 32'h1;
      end
    end
    if (rden && addr == 2'b01)      tm_dout <= tm_period - {31'h0, rb_corrupt};
    else if (rden && addr == 2'b10) tm_dout <= {29'h0, tm_flag, 1'b0, tm_en};
    else                            tm_dout <= 32'h0;
  end

  // One clock, then bus-rule bookkeeping at the falling edge.
  task automatic step();
    @(negedge clk);
    if (reset) begin
      if (wren && rden) proto_bad++;
      if (!wren && !rden && (addr != 2'b00 || din != 32'h0)) proto_bad++;
      if ({busy4, tick4, err4, addr4, din4, wren4, rden4} !== {busy, tick, err, addr, din, wren, rden})
        proto_bad++;
      if (wren) begin wr_addr_q.push_back(addr); wr_din_q.push_back(din); end
      if (tick) tick_seen++;
    end
  endtask

  task automatic do_start(input logic [31:0] p, input logic with_stop);
    tm_clr = 1'b1; step(); tm_clr = 1'b0;
    wr_addr_q.delete(); wr_din_q.delete(); tick_seen = 0;
    start = 1'b1; stop = with_stop; period_in = p;
    step();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_toggles(input int n, input int budget, input string nm);
    int k = 0;
    while (tm_toggles < n && k < budget) begin step(); k++; end
    total++;
    if (tm_toggles < n) begin bad++; $display("FAIL %s timeout: toggles=%0d need=%0d", nm, tm_toggles, n); end
    repeat (8) step();
  endtask

  task automatic wait_poll();
    int k = 0;
    while (!(rden && addr == 2'b10) && k < 40) begin step(); k++; end
    total++;
    if (!(rden && addr == 2'b10)) begin bad++; $display("FAIL poll_wait timeout: rden=%b addr=%b", rden, addr); end
  endtask

  // Issue stop in the current cycle; WR_DIS must follow within 2 cycles and busy drop after it.
  task automatic stop_check(input string nm);
    int k = 0;
    bit seen = 0;
    stop = 1'b1; step(); stop = 1'b0; k = 1;
    while (k <= 2 && !seen) begin
      if (wren && addr == 2'b10 && din == 32'h0) seen = 1; else begin step(); k++; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s wr_dis: not seen within 2 cycles, wren=%b addr=%b din=%h", nm, wren, addr, din); end
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_after_dis: got %b want 0", nm, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b0; tm_clr = 1'b1;
    repeat (3) step();
    total++;
    if ({busy, tick, err, wren, rden} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {busy, tick, err, wren, rden});
    end
    total++;
    if ({addr, din, tick_count} !== 50'h0) begin
      bad++; $display("FAIL reset_data: addr=%b din=%h count=%0d want 0", addr, din, tick_count);
    end
    reset = 1'b1; step(); tm_clr = 1'b0; step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    // asynchronous reset while a poll read is on the bus
    tm_limit = 1000;
    do_start(32'd5, 1'b0);
    wait_poll();
    #2 reset = 1'b0;
    #1;
    total++;
    if ({rden, busy, addr} !== 4'b0) begin
      bad++; $display("FAIL reset_async: rden=%b busy=%b addr=%b want 0", rden, busy, addr);
    end
    step(); reset = 1'b1; step(); step();
    total++;
    if (busy !== 1'b0 || wren !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b wren=%b want 0", busy, wren); end
  endtask

  task automatic test_basic();
    tm_limit = 5;
    do_start(32'd10, 1'b1);
    total++;
    if (!(wren && addr == 2'b01 && din == 32'd10 && busy)) begin
      bad++; $display("FAIL basic_wr_per: wren=%b addr=%b din=%0d busy=%b want 1/01/10/1", wren, addr, din, busy);
    end
    repeat (EN_LAT) step();
    total++;
    if (!(wren && addr == 2'b10 && din == 32'h1)) begin
      bad++; $display("FAIL basic_wr_en: wren=%b addr=%b din=%h want 1/10/1", wren, addr, din);
    end
    wait_toggles(5, 200, "basic");
    total++;
    if (tick_count !== 16'd5 || tick_seen != 5) begin
      bad++; $display("FAIL basic_count: count=%0d ticks=%0d want 5", tick_count, tick_seen);
    end
    wait_poll();
    stop_check("basic");
    total++;
    if (err !== 1'b0 || wr_addr_q.size() != 3) begin
      bad++; $display("FAIL basic_writes: err=%b writes=%0d want 0/3", err, wr_addr_q.size());
    end
  endtask

  task automatic test_min_period();
    tm_limit = 100;
    do_start(32'd0, 1'b0);
    total++;
    if (!(wren && addr == 2'b01 && din == 32'd2)) begin
      bad++; $display("FAIL min_period_din: addr=%b din=%0d want 01/2", addr, din);
    end
    wait_toggles(100, 1000, "min_period");
    total++;
    if (tick_count !== 16'd100 || tc4 !== 4'd4) begin
      bad++; $display("FAIL min_period_count: count=%0d count4=%0d want 100/4", tick_count, tc4);
    end
    wait_poll();
    stop_check("min_period");
  endtask

  task automatic test_wrap();
    tm_limit = 16;
    do_start(32'd3, 1'b0);
    wait_toggles(16, 300, "wrap");
    total++;
    if (tc4 !== 4'd0 || tick_count !== 16'd16) begin
      bad++; $display("FAIL wrap_count: count4=%0d count=%0d want 0/16", tc4, tick_count);
    end
    wait_poll();
    stop_check("wrap");
  endtask

  task automatic test_back_to_back();
    int nw;
    tm_limit = 1000;
    do_start(32'd4, 1'b0);
    repeat ($urandom_range(8, 20)) step();
    nw = wr_addr_q.size();
    start = 1'b1; period_in = 32'd7; step(); start = 1'b0;
    repeat (4) step();
    total++;
    if (wr_addr_q.size() != nw || nw != 2) begin
      bad++; $display("FAIL b2b_start_ignored: writes=%0d want 2", wr_addr_q.size());
    end
    wait_poll();
    step();
    stop_check("b2b_poll_wait");
    total++;
    if (wr_addr_q.size() != 3 || wr_din_q[2] != 32'h0 || wr_addr_q[2] != 2'b10) begin
      bad++; $display("FAIL b2b_last_write: writes=%0d want 3 ending 10/0", wr_addr_q.size());
    end
    stop = 1'b1; step(); stop = 1'b0; step();
    total++;
    if (busy !== 1'b0 || wren !== 1'b0) begin
      bad++; $display("FAIL idle_stop_ignored: busy=%b wren=%b want 0", busy, wren);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [31:0] p;
      int lim;
      p = 32'($urandom_range(0, 12));
      lim = $urandom_range(1, 25);
      tm_limit = lim;
      do_start(p, 1'b0);
      total++;
      if (din != ((p < 32'd2) ? 32'd2 : p)) begin
        bad++; $display("FAIL rand%0d_din: got %0d want %0d", it, din, (p < 32'd2) ? 32'd2 : p);
      end
      wait_toggles(lim, lim * 16 + 100, "rand");
      total++;
      if (tick_count !== 16'(lim) || tc4 !== 4'(lim) || tick_seen != lim) begin
        bad++; $display("FAIL rand%0d_count: count=%0d count4=%0d ticks=%0d want %0d", it, tick_count, tc4, tick_seen, lim);
      end
      wait_poll();
      repeat ($urandom_range(0, 1)) step();
      stop_check("rand");
    end
  endtask

  task automatic test_readback();
    tm_limit = 1000;
    rb_corrupt = 1'b1;
    do_start(32'd10, 1'b0);
    repeat (10) step();
    rb_corrupt = 1'b0;
`ifdef TIMER_MASTER_READBACK_EN
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rb_err: err=%b busy=%b want 1/0", err, busy); end
    total++;
    if (wr_addr_q.size() != 2 || wr_addr_q[1] != 2'b10 || wr_din_q[1] != 32'h0) begin
      bad++; $display("FAIL rb_no_enable: writes=%0d want 2 ending 10/0", wr_addr_q.size());
    end
    do_start(32'd5, 1'b0);
    repeat (6) step();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL rb_err_cleared: got %b want 0", err); end
    wait_poll();
    stop_check("rb_restart");
`else
    total++;
    if (err !== 1'b0 || busy !== 1'b1 || wr_addr_q.size() != 2 || wr_din_q[1] != 32'h1) begin
      bad++; $display("FAIL no_rb: err=%b busy=%b writes=%0d want 0/1/2 with EN", err, busy, wr_addr_q.size());
    end
    wait_poll();
    stop_check("no_rb");
`endif
  endtask

  task automatic test_protocol();
    total++;
    if (proto_bad != 0) begin bad++; $display("FAIL bus_rules: violations=%0d want 0", proto_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_period();
    test_wrap();
    test_back_to_back();
    test_random();
    test_readback();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
